// File: rtl/uart_rx_frame_ctrl.sv
// Frames the uart_rx byte stream (SOF, ADDR, LEN, payload[, CSUM]) into buffered write bursts.
// Define UART_FRAME_CSUM_EN to require and verify a trailing checksum byte.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  SOF_BYTE    = 8'hA5,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 43_400
) (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       rx_error,
    input  logic       rx_idle,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(MAX_LEN + 1);
    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [7:0]      MaxLenB = 8'(MAX_LEN);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ErrNone = 3'd0;
    localparam logic [2:0] ErrRx   = 3'd1;
    localparam logic [2:0] ErrLen  = 3'd2;
    localparam logic [2:0] ErrTmo  = 3'd3;

`ifdef UART_FRAME_CSUM_EN
    localparam logic [2:0] ErrCsum = 3'd4;
    typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StCsum, StWrite} state_e;
`else
    typedef enum logic [2:0] {StIdle, StAddr, StLen, StData, StWrite} state_e;
`endif

    state_e          state_q;
    logic            rx_ready_q;
    logic            rx_error_q;
    logic [7:0]      base_q;
    logic [CntW-1:0] len_q;
    logic [CntW-1:0] idx_q;
    logic [TmoW-1:0] tmo_q;
    logic [7:0]      frame_buf [MAX_LEN];

    logic            byte_strb;
    logic            err_strb;
    logic            in_frame;
    logic            len_bad;
    logic            buf_we;
    logic            abort_req;
    logic [2:0]      abort_code;
    logic [CntW-1:0] idx_nxt;

    // Line-idle status is not needed for sequencing.
    logic unused_rx_idle;
    assign unused_rx_idle = rx_idle;

    assign byte_strb = rx_ready & ~rx_ready_q;
    assign err_strb  = rx_error & ~rx_error_q;
    assign len_bad   = (rx_data == 8'd0) || (rx_data > MaxLenB);
    assign idx_nxt   = idx_q + CntW'(1);

`ifdef UART_FRAME_CSUM_EN
    logic [7:0] sum_q;
    logic [7:0] csum_total;
    assign csum_total = sum_q + rx_data;
    assign in_frame   = state_q inside {StAddr, StLen, StData, StCsum};
`else
    assign in_frame   = state_q inside {StAddr, StLen, StData};
`endif

    // A framing error outranks a byte arriving in the same cycle; timeout only fires on silence.
    always_comb begin
        abort_req  = 1'b0;
        abort_code = ErrNone;
        if (in_frame) begin
            if (err_strb) begin
                abort_req  = 1'b1;
                abort_code = ErrRx;
            end else if (byte_strb) begin
                if (state_q == StLen && len_bad) begin
                    abort_req  = 1'b1;
                    abort_code = ErrLen;
                end
`ifdef UART_FRAME_CSUM_EN
                if (state_q == StCsum && csum_total != 8'h00) begin
                    abort_req  = 1'b1;
                    abort_code = ErrCsum;
                end
`endif
            end else if (tmo_q == TmoLast) begin
                abort_req  = 1'b1;
                abort_code = ErrTmo;
            end
        end
    end

    assign buf_we = (state_q == StData) && byte_strb && !err_strb;

    // Payload storage needs no reset: it is only read back after being written in this frame.
    always_ff @(posedge clk50m) begin
        if (buf_we) begin
            frame_buf[idx_q[IdxW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rx_ready_q <= 1'b0;
            rx_error_q <= 1'b0;
            base_q     <= 8'd0;
            len_q      <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
`ifdef UART_FRAME_CSUM_EN
            sum_q      <= 8'd0;
`endif
            wr_en      <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= 8'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ErrNone;
            busy       <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            rx_error_q <= rx_error;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (abort_req) begin
                frame_err <= 1'b1;
                err_code  <= abort_code;
                state_q   <= StIdle;
                busy      <= 1'b0;
                idx_q     <= '0;
                tmo_q     <= '0;
            end else begin
                // Every state entry inside a frame coincides with a byte, so this also clears on entry.
                if (byte_strb || !in_frame) begin
                    tmo_q <= '0;
                end else begin
                    tmo_q <= tmo_q + TmoW'(1);
                end

                case (state_q)
                    StIdle: begin
                        if (byte_strb && rx_data == SOF_BYTE) begin
                            state_q <= StAddr;
                            busy    <= 1'b1;
                        end
                    end
                    StAddr: begin
                        if (byte_strb) begin
                            base_q  <= rx_data;
`ifdef UART_FRAME_CSUM_EN
                            sum_q   <= rx_data;
`endif
                            state_q <= StLen;
                        end
                    end
                    StLen: begin
                        if (byte_strb) begin
                            len_q   <= rx_data[CntW-1:0];
                            idx_q   <= '0;
`ifdef UART_FRAME_CSUM_EN
                            sum_q   <= csum_total;
`endif
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        if (byte_strb) begin
`ifdef UART_FRAME_CSUM_EN
                            sum_q <= csum_total;
`endif
                            if (idx_nxt == len_q) begin
                                idx_q <= '0;
`ifdef UART_FRAME_CSUM_EN
                                state_q <= StCsum;
`else
                                state_q <= StWrite;
`endif
                            end else begin
                                idx_q <= idx_nxt;
                            end
                        end
                    end
`ifdef UART_FRAME_CSUM_EN
                    StCsum: begin
                        if (byte_strb) begin
                            state_q <= StWrite;
                        end
                    end
`endif
                    StWrite: begin
                        if (idx_q == len_q) begin
                            frame_done <= 1'b1;
                            err_code   <= ErrNone;
                            state_q    <= StIdle;
                            busy       <= 1'b0;
                            idx_q      <= '0;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= base_q + 8'(idx_q);
                            wr_data <= frame_buf[idx_q[IdxW-1:0]];
                            idx_q   <= idx_nxt;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
